muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit that extends the core's single-cycle integer ALU with the RISC-V M-extension operations. It sits beside the ALU in the execute stage, takes operands with a start pulse, runs a radix-2 shift-add multiply or restoring divide over XLEN cycles, and returns one registered result with a single-cycle done pulse. The pipeline stalls on busy_o.

---
 rtl/muldiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle over
// XLEN cycles, followed by a sign-fix cycle and a one-cycle done pulse.
// Divide by zero and signed overflow skip the iteration and go straight to fix.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [2:0]      func_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    logic              busy;
    logic              done;
    logic [XLEN-1:0]   result;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic              neg1;        // rs1 is negative under its op's signedness
    logic              neg2;        // rs2 is negative under its op's signedness
    logic              special;     // divide short-cut, answer already known
    logic [XLEN-1:0]   special_res;
    logic [XLEN-1:0]   mcand;       // multiplicand magnitude
    logic [XLEN-1:0]   divisor;     // divisor magnitude
    logic [2*XLEN-1:0] acc;         // product accumulator, multiplier in low half
    logic [XLEN-1:0]   prem;        // partial remainder
    logic [XLEN-1:0]   quo;         // dividend shifting out, quotient shifting in

    // accept-time decode: signedness, magnitudes and divide short-cuts
    logic            sgn1, sgn2;
    logic            in_neg1, in_neg2;
    logic [XLEN-1:0] in_mag1, in_mag2;
    logic            div_zero, div_ovf, in_special;
    logic [XLEN-1:0] in_spec_res;

    // decode the incoming request into signs, magnitudes and special answers
    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        case (func_i)
            F_MULH, F_DIV, F_REM: begin
                sgn1 = 1'b1;
                sgn2 = 1'b1;
            end
            F_MULHSU: sgn1 = 1'b1;
            default: ;
        endcase
        in_neg1  = sgn1 & src1_i[XLEN-1];
        in_neg2  = sgn2 & src2_i[XLEN-1];
        in_mag1  = in_neg1 ? -src1_i : src1_i;
        in_mag2  = in_neg2 ? -src2_i : src2_i;
        div_zero = func_i[2] && (src2_i == '0);
        div_ovf  = ((func_i == F_DIV) || (func_i == F_REM)) &&
                   (src1_i == MIN_NEG) && (src2_i == '1);
        in_special = div_zero | div_ovf;
        // func_i[1] separates remainder from quotient among the divide ops
        if (div_zero)
            in_spec_res = func_i[1] ? src1_i : '1;
        else
            in_spec_res = func_i[1] ? '0 : src1_i;
    end

    // one iteration step for each algorithm
    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_shift;
    logic [XLEN:0] div_diff;

    // shift-add and restoring-subtract step values from current state
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        div_shift = {prem, quo[XLEN-1]};
        div_diff  = div_shift - {1'b0, divisor};
    end

    // sign correction and output select for the fix cycle
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   qv, rv, fix_res;

    // apply operand signs to the unsigned result and pick the requested half
    always_comb begin
        prod = (neg1 ^ neg2) ? -acc : acc;
        qv   = (neg1 ^ neg2) ? -quo : quo;
        rv   = neg1 ? -prem : prem;
        case (op)
            F_MUL:                     fix_res = prod[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:             fix_res = qv;
            default:                   fix_res = rv;
        endcase
        if (special)
            fix_res = special_res;
    end

    // control FSM with datapath registers and registered busy/done outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            cnt         <= '0;
            op          <= '0;
            neg1        <= 1'b0;
            neg2        <= 1'b0;
            special     <= 1'b0;
            special_res <= '0;
            mcand       <= '0;
            divisor     <= '0;
            acc         <= '0;
            prem        <= '0;
            quo         <= '0;
        end else begin
            done <= 1'b0;
            if (kill_i) begin
                // flush wins over everything, including a same-cycle start
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start_i) begin
                            op          <= func_i;
                            neg1        <= in_neg1;
                            neg2        <= in_neg2;
                            special     <= in_special;
                            special_res <= in_spec_res;
                            mcand       <= in_mag1;
                            divisor     <= in_mag2;
                            acc         <= {{XLEN{1'b0}}, in_mag2};
                            prem        <= '0;
                            quo         <= in_mag1;
                            cnt         <= CW'(XLEN);
                            busy        <= 1'b1;
                            state       <= in_special ? FIX : CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    CALC: begin
                        cnt <= cnt - 1'b1;
                        if (op[2]) begin
                            // restore by keeping the shifted value when the trial borrows
                            if (!div_diff[XLEN]) begin
                                prem <= div_diff[XLEN-1:0];
                                quo  <= {quo[XLEN-2:0], 1'b1};
                            end else begin
                                prem <= div_shift[XLEN-1:0];
                                quo  <= {quo[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            acc <= {mul_sum, acc[XLEN-1:1]};
                        end
                        if (cnt == CW'(1))
                            state <= FIX;
                    end
                    FIX: begin
                        result <= fix_res;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_o   = busy;
    assign done_o   = done;
    assign result_o = result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed M-extension vectors at XLEN=32 and 8,
// randomized ops against an arithmetic reference, kill, reset, busy-ignore
// and back-to-back timing.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start32 = 1'b0, kill32 = 1'b0;
    logic [2:0]  func32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [31:0] res32;

    logic        start8 = 1'b0, kill8 = 1'b0;
    logic [2:0]  func8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [7:0]  res8;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk_i(clk), .reset_i(rst), .start_i(start32), .func_i(func32),
        .src1_i(a32), .src2_i(b32), .kill_i(kill32),
        .busy_o(busy32), .done_o(done32), .result_o(res32)
    );

    muldiv_unit #(.XLEN(8)) dut8 (
        .clk_i(clk), .reset_i(rst), .start_i(start8), .func_i(func8),
        .src1_i(a8), .src2_i(b8), .kill_i(kill8),
        .busy_o(busy8), .done_o(done8), .result_o(res8)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] last32 = '0;
    logic [7:0]  last8 = '0;

    typedef struct {
        bit          w8;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    // reference: plain integer arithmetic on sign-interpreted operands
    function automatic longint ref_model(int xlen, logic [2:0] f, longint a_in, longint b_in);
        longint mask, ua, ub, sa, sb, minv, r;
        mask = (longint'(1) << xlen) - 1;
        minv = -(longint'(1) << (xlen - 1));
        ua = a_in & mask;
        ub = b_in & mask;
        sa = ua[xlen-1] ? ua - mask - 1 : ua;
        sb = ub[xlen-1] ? ub - mask - 1 : ub;
        case (f)
            3'd0: r = ua * ub;
            3'd1: r = (sa * sb) >> xlen;
            3'd2: r = (sa * ub) >> xlen;
            3'd3: r = (ua * ub) >> xlen;
            3'd4: r = (ub == 0) ? mask : ((sa == minv && sb == -1) ? ua : sa / sb);
            3'd5: r = (ub == 0) ? mask : ua / ub;
            3'd6: r = (ub == 0) ? ua : ((sa == minv && sb == -1) ? 0 : sa % sb);
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return r & mask;
    endfunction

    function automatic bit is_special(int xlen, logic [2:0] f, longint a, longint b);
        longint mask, minv;
        mask = (longint'(1) << xlen) - 1;
        minv = longint'(1) << (xlen - 1);
        if (f[2] && (b & mask) == 0) return 1'b1;
        if ((f == 3'd4 || f == 3'd6) && (a & mask) == minv && (b & mask) == mask) return 1'b1;
        return 1'b0;
    endfunction

    // issue one op and follow it to done; returns at the negedge of the done cycle.
    // lat counts edges after the accept edge; -1 means no done within the bound.
    task automatic issue(input bit w8, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res, output int lat,
                         output bit both_hi, output bit busy_gap);
        int n;
        logic bsy, dn;
        @(negedge clk);
        if (w8) begin func8 = f; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; end
        else begin func32 = f; a32 = a; b32 = b; start32 = 1'b1; end
        @(negedge clk);
        start8 = 1'b0;
        start32 = 1'b0;
        lat = -1; both_hi = 1'b0; busy_gap = 1'b0; res = '0; n = 0;
        while (n < 100) begin
            bsy = w8 ? busy8 : busy32;
            dn  = w8 ? done8 : done32;
            if (bsy && dn) both_hi = 1'b1;
            if (dn) begin
                lat = n;
                res = w8 ? {24'b0, res8} : res32;
                break;
            end
            if (!bsy) busy_gap = 1'b1;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'h0) begin
            failures++;
            $display("FAIL reset32 got busy=%b done=%b res=%h exp 0/0/0", busy32, done32, res32);
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'h0) begin
            failures++;
            $display("FAIL reset8 got busy=%b done=%b res=%h exp 0/0/0", busy8, done8, res8);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul();
        vec_t tbl [8];
        logic [31:0] res; int lat; bit both, gap;
        tbl[0] = '{1'b0, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        tbl[1] = '{1'b0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33};
        tbl[2] = '{1'b0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        tbl[3] = '{1'b0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        tbl[4] = '{1'b1, 3'd0, 32'd7,        32'hFD,       32'hEB,       9};
        tbl[5] = '{1'b1, 3'd1, 32'h80,       32'h80,       32'h40,       9};
        tbl[6] = '{1'b1, 3'd2, 32'hFF,       32'hFF,       32'hFF,       9};
        tbl[7] = '{1'b1, 3'd3, 32'hFF,       32'hFF,       32'hFE,       9};
        foreach (tbl[i]) begin
            issue(tbl[i].w8, tbl[i].f, tbl[i].a, tbl[i].b, res, lat, both, gap);
            checks++;
            if (res !== tbl[i].exp) begin
                failures++;
                $display("FAIL mul[%0d] result got=%h exp=%h", i, res, tbl[i].exp);
            end
            checks++;
            if (lat != tbl[i].lat) begin
                failures++;
                $display("FAIL mul[%0d] latency got=%0d exp=%0d", i, lat, tbl[i].lat);
            end
            checks++;
            if (both || gap) begin
                failures++;
                $display("FAIL mul[%0d] busy got both=%b gap=%b exp 0/0", i, both, gap);
            end
            if (tbl[i].w8) last8 = tbl[i].exp[7:0]; else last32 = tbl[i].exp;
        end
    endtask

    task automatic test_div();
        vec_t tbl [8];
        logic [31:0] res; int lat; bit both, gap;
        tbl[0] = '{1'b0, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33};
        tbl[1] = '{1'b0, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33};
        tbl[2] = '{1'b0, 3'd5, 32'd100,      32'd7, 32'd14,       33};
        tbl[3] = '{1'b0, 3'd7, 32'd100,      32'd7, 32'd2,        33};
        tbl[4] = '{1'b1, 3'd4, 32'hF9,       32'd2, 32'hFD,       9};
        tbl[5] = '{1'b1, 3'd6, 32'hF9,       32'd2, 32'hFF,       9};
        tbl[6] = '{1'b1, 3'd5, 32'd100,      32'd7, 32'd14,       9};
        tbl[7] = '{1'b1, 3'd7, 32'd100,      32'd7, 32'd2,        9};
        foreach (tbl[i]) begin
            issue(tbl[i].w8, tbl[i].f, tbl[i].a, tbl[i].b, res, lat, both, gap);
            checks++;
            if (res !== tbl[i].exp) begin
                failures++;
                $display("FAIL div[%0d] result got=%h exp=%h", i, res, tbl[i].exp);
            end
            checks++;
            if (lat != tbl[i].lat) begin
                failures++;
                $display("FAIL div[%0d] latency got=%0d exp=%0d", i, lat, tbl[i].lat);
            end
            checks++;
            if (both || gap) begin
                failures++;
                $display("FAIL div[%0d] busy got both=%b gap=%b exp 0/0", i, both, gap);
            end
            if (tbl[i].w8) last8 = tbl[i].exp[7:0]; else last32 = tbl[i].exp;
        end
    endtask

    task automatic test_div_special();
        vec_t tbl [8];
        logic [31:0] res; int lat; bit both, gap;
        tbl[0] = '{1'b0, 3'd5, 32'h1234,     32'h0,        32'hFFFFFFFF, 1};
        tbl[1] = '{1'b0, 3'd6, 32'h1234,     32'h0,        32'h1234,     1};
        tbl[2] = '{1'b0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        tbl[3] = '{1'b0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1};
        tbl[4] = '{1'b1, 3'd5, 32'h34,       32'h0,        32'hFF,       1};
        tbl[5] = '{1'b1, 3'd6, 32'h34,       32'h0,        32'h34,       1};
        tbl[6] = '{1'b1, 3'd4, 32'h80,       32'hFF,       32'h80,       1};
        tbl[7] = '{1'b1, 3'd6, 32'h80,       32'hFF,       32'h0,        1};
        foreach (tbl[i]) begin
            issue(tbl[i].w8, tbl[i].f, tbl[i].a, tbl[i].b, res, lat, both, gap);
            checks++;
            if (res !== tbl[i].exp) begin
                failures++;
                $display("FAIL special[%0d] result got=%h exp=%h", i, res, tbl[i].exp);
            end
            checks++;
            if (lat != tbl[i].lat) begin
                failures++;
                $display("FAIL special[%0d] latency got=%0d exp=%0d", i, lat, tbl[i].lat);
            end
            if (tbl[i].w8) last8 = tbl[i].exp[7:0]; else last32 = tbl[i].exp;
        end
    endtask

    task automatic test_random();
        logic [31:0] res, a, b, exp; int lat, xl, exp_lat; bit both, gap, w8;
        logic [2:0] f;
        logic [31:0] corner [5];
        for (int i = 0; i < 60; i++) begin
            w8 = i[0];
            xl = w8 ? 8 : 32;
            corner[0] = 32'd0;
            corner[1] = 32'd1;
            corner[2] = w8 ? 32'hFF : 32'hFFFFFFFF;
            corner[3] = w8 ? 32'h80 : 32'h80000000;
            corner[4] = $urandom_range(2, 9);
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            if (w8) begin a = a & 32'hFF; b = b & 32'hFF; end
            exp = 32'(ref_model(xl, f, longint'({32'b0, a}), longint'({32'b0, b})));
            exp_lat = is_special(xl, f, longint'({32'b0, a}), longint'({32'b0, b})) ? 1 : xl + 1;
            issue(w8, f, a, b, res, lat, both, gap);
            checks++;
            if (res !== exp || lat != exp_lat || both || gap) begin
                failures++;
                $display("FAIL rand[%0d] x%0d f=%0d a=%h b=%h got res=%h lat=%0d both=%b gap=%b exp res=%h lat=%0d",
                         i, xl, f, a, b, res, lat, both, gap, exp, exp_lat);
            end
            if (w8) last8 = exp[7:0]; else last32 = exp;
        end
    endtask

    task automatic test_kill();
        bit saw_done;
        logic [31:0] prev;
        prev = last32;
        @(negedge clk);
        func32 = 3'd0; a32 = $urandom; b32 = $urandom; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        kill32 = 1'b1;
        @(negedge clk);
        kill32 = 1'b0;
        checks++;
        if (busy32 !== 1'b0) begin
            failures++;
            $display("FAIL kill busy got=%b exp=0", busy32);
        end
        saw_done = 1'b0;
        repeat (40) begin
            if (done32) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL kill done got=1 exp=0");
        end
        checks++;
        if (res32 !== prev) begin
            failures++;
            $display("FAIL kill result got=%h exp=%h", res32, prev);
        end
        func32 = 3'd3; a32 = $urandom; b32 = $urandom; start32 = 1'b1; kill32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        kill32 = 1'b0;
        checks++;
        if (busy32 !== 1'b0) begin
            failures++;
            $display("FAIL start_kill busy got=%b exp=0", busy32);
        end
        saw_done = 1'b0;
        repeat (40) begin
            if (done32) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_done || res32 !== prev) begin
            failures++;
            $display("FAIL start_kill done/result got done=%b res=%h exp 0/%h", saw_done, res32, prev);
        end
    endtask

    task automatic test_busy_ignore();
        int n, lat;
        bit saw_done;
        logic [31:0] a, b, exp;
        a = $urandom; b = $urandom;
        exp = 32'(ref_model(32, 3'd1, longint'({32'b0, a}), longint'({32'b0, b})));
        @(negedge clk);
        func32 = 3'd1; a32 = a; b32 = b; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        n = 0; lat = -1;
        while (n < 100) begin
            if (done32) begin lat = n; break; end
            start32 = (n == 5);
            if (n == 5) begin func32 = 3'd5; a32 = 32'd99; b32 = 32'd3; end
            @(negedge clk);
            n++;
        end
        start32 = 1'b0;
        checks++;
        if (lat != 33 || res32 !== exp) begin
            failures++;
            $display("FAIL busy_ignore got lat=%0d res=%h exp lat=33 res=%h", lat, res32, exp);
        end
        saw_done = 1'b0;
        @(negedge clk);
        repeat (40) begin
            if (done32) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL busy_ignore extra done got=1 exp=0");
        end
        last32 = exp;
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        @(negedge clk);
        func32 = 3'd0; a32 = 32'd12345; b32 = 32'd678; start32 = 1'b1;
        func8 = 3'd5; a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        start8 = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'h0 ||
            busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'h0) begin
            failures++;
            $display("FAIL reset_mid got b32=%b d32=%b r32=%h b8=%b d8=%b r8=%h exp all 0",
                     busy32, done32, res32, busy8, done8, res8);
        end
        @(negedge clk);
        rst = 1'b0;
        last32 = '0;
        last8 = '0;
        saw_done = 1'b0;
        repeat (50) begin
            if (done32 || done8 || busy32 || busy8) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL reset_mid activity after release got=1 exp=0");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, a1, b1, a2, b2, e1, e2;
        int lat, n;
        bit both, gap;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        e1 = 32'(ref_model(32, 3'd0, longint'({32'b0, a1}), longint'({32'b0, b1})));
        e2 = 32'(ref_model(32, 3'd0, longint'({32'b0, a2}), longint'({32'b0, b2})));
        issue(1'b0, 3'd0, a1, b1, res, lat, both, gap);
        checks++;
        if (res !== e1 || lat != 33) begin
            failures++;
            $display("FAIL b2b first got res=%h lat=%0d exp res=%h lat=33", res, lat, e1);
        end
        // still in the done cycle: issue the next op right here
        func32 = 3'd0; a32 = a2; b32 = b2; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        checks++;
        if (busy32 !== 1'b1 || done32 !== 1'b0) begin
            failures++;
            $display("FAIL b2b accept got busy=%b done=%b exp 1/0", busy32, done32);
        end
        n = 1; lat = -1;
        while (n < 100) begin
            if (done32) begin lat = n; break; end
            @(negedge clk);
            n++;
        end
        checks++;
        if (lat != 34 || res32 !== e2) begin
            failures++;
            $display("FAIL b2b second got gap=%0d res=%h exp gap=34 res=%h", lat, res32, e2);
        end
        last32 = e2;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_random();
        test_kill();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
